// File: rtl/qpsk_pkg.sv
// Shared constants, state type and symbol payload for the QPSK transmit sequencer.
package qpsk_pkg;

    localparam int unsigned UPSAMPLE   = 4;
    localparam int unsigned PHASE_W    = $clog2(UPSAMPLE);
    localparam int unsigned SYM_W      = 2;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned UCNT_W     = 8;

    localparam logic [SYM_W-1:0] SYM_POS  = 2'b01;
    localparam logic [SYM_W-1:0] SYM_NEG  = 2'b11;
    localparam logic [SYM_W-1:0] SYM_ZERO = 2'b00;

    // Last phase of a symbol period; the edge leaving it opens the next slot.
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(UPSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [SYM_W-1:0] i;
        logic [SYM_W-1:0] q;
    } sym_pair_t;

    function automatic logic [SYM_W-1:0] map_bit(input logic b);
        return b ? SYM_NEG : SYM_POS;
    endfunction

endpackage

// File: rtl/qpsk_sym_fifo.sv
// Two-entry symbol FIFO; head_c presents the oldest entry combinationally.
module qpsk_sym_fifo
    import qpsk_pkg::*;
(
    input  logic                  clk_fs,
    input  logic                  rst_n,
    input  logic                  push,
    input  sym_pair_t             push_data,
    input  logic                  pop,
    output sym_pair_t             head_c,
    output logic [FIFO_CNT_W-1:0] count
);

    sym_pair_t             mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    // Push when full and pop when empty are ignored.
    assign do_push = push && (count != FIFO_CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head_c  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_tx_sequencer.sv
// QPSK transmit sequencer: pairs serial bits into I/Q symbols and emits them zero-stuffed x4.
// Optional saturating underrun counter port enabled by defining QPSK_UNDERRUN_CNT_EN.
module qpsk_tx_sequencer
    import qpsk_pkg::*;
(
    input  logic             clk_fs,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [SYM_W-1:0] data_I_out,
    output logic [SYM_W-1:0] data_Q_out,
    output logic             sym_strobe,
    output logic             busy,
    output logic             underrun
`ifdef QPSK_UNDERRUN_CNT_EN
    ,
    output logic [UCNT_W-1:0] underrun_cnt
`endif
);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_d;
    logic                  half_vld_q;
    logic                  half_vld_d;
    logic                  half_bit_q;
    logic                  half_bit_d;
    sym_pair_t             sym_d;
    logic                  strobe_d;
    logic                  underrun_d;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  slot;
    logic                  fifo_empty;
    sym_pair_t             push_pair;
    sym_pair_t             fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;

    // Ready is held low during reset even though en may already be high.
    assign bit_ready  = rst_n && en && (fifo_count < FIFO_CNT_W'(FIFO_DEPTH));
    assign accept     = bit_valid && bit_ready;
    assign push       = accept && half_vld_q;
    assign push_pair  = '{i: map_bit(half_bit_q), q: map_bit(bit_in)};
    assign slot       = (phase_q == PHASE_LAST);
    assign fifo_empty = (fifo_count == '0);

    qpsk_sym_fifo u_sym_fifo (
        .clk_fs    (clk_fs),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_pair),
        .pop       (pop),
        .head_c    (fifo_head),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slot actions and bit pairing.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sym_d      = '{i: SYM_ZERO, q: SYM_ZERO};
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        pop        = 1'b0;
        half_vld_d = half_vld_q;
        half_bit_d = half_bit_q;

        if (accept) begin
            half_vld_d = ~half_vld_q;
            if (!half_vld_q) begin
                half_bit_d = bit_in;
            end
        end

        case (state_q)
            IDLE: begin
                phase_d = '0;
                // Preload the last phase so the very next edge opens a slot.
                if (en && !fifo_empty) begin
                    state_d = RUN;
                    phase_d = PHASE_LAST;
                end
            end
            RUN: begin
                phase_d = phase_q + PHASE_W'(1);
                if (slot) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        sym_d    = fifo_head;
                        strobe_d = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                phase_d = phase_q + PHASE_W'(1);
                if (slot) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        sym_d    = fifo_head;
                        strobe_d = 1'b1;
                    end else if (!en) begin
                        state_d    = IDLE;
                        phase_d    = '0;
                        half_vld_d = 1'b0;
                    end
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Phase counter, half-pair holding register and registered outputs.
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            half_vld_q <= 1'b0;
            half_bit_q <= 1'b0;
            data_I_out <= SYM_ZERO;
            data_Q_out <= SYM_ZERO;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            half_vld_q <= half_vld_d;
            half_bit_q <= half_bit_d;
            data_I_out <= sym_d.i;
            data_Q_out <= sym_d.q;
            sym_strobe <= strobe_d;
            underrun   <= underrun_d;
            busy       <= (state_d != IDLE);
        end
    end

`ifdef QPSK_UNDERRUN_CNT_EN
    // Saturating underrun tally, restarted each time transmission starts from IDLE.
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if ((state_q == IDLE) && (state_d == RUN)) begin
            underrun_cnt <= '0;
        end else if (underrun_d && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_tx_sequencer.sv
// Self-checking bench for qpsk_tx_sequencer: directed scenarios plus random traffic vs a queue model.
`timescale 1ns/1ps
module tb_qpsk_tx_sequencer;

    logic       clk_fs = 1'b0;
    logic       rst_n;
    logic       en;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [1:0] data_I_out;
    logic [1:0] data_Q_out;
    logic       sym_strobe;
    logic       busy;
    logic       underrun;
`ifdef QPSK_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt;
`endif

    always #50 clk_fs = ~clk_fs;

    qpsk_tx_sequencer dut (
        .clk_fs     (clk_fs),
        .rst_n      (rst_n),
        .en         (en),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .data_I_out (data_I_out),
        .data_Q_out (data_Q_out),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .underrun   (underrun)
`ifdef QPSK_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of {I,Q} symbols, a half-pair bit and a symbol-period counter.
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    int         m_st;
    int         m_ph;
    bit         m_half;
    bit         m_hbit;
    logic [3:0] m_fifo [$];
    logic [1:0] m_i;
    logic [1:0] m_q;
    bit         m_stb;
    bit         m_und;
    bit         m_busy;
    int         m_ucnt;

    function automatic logic [1:0] sym_of(input bit b);
        return b ? 2'b11 : 2'b01;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_ph = 0; m_half = 0; m_hbit = 0;
        m_fifo.delete();
        m_i = 2'b00; m_q = 2'b00; m_stb = 0; m_und = 0; m_busy = 0; m_ucnt = 0;
    endtask

    task automatic model_edge(input bit e, input bit v, input bit b);
        bit         acc;
        int         nst;
        int         nph;
        logic [3:0] p;
        acc = e && v && (m_fifo.size() < 2);
        nst = m_st;
        nph = 0;
        m_i = 2'b00; m_q = 2'b00; m_stb = 0; m_und = 0;
        if (m_st == M_IDLE) begin
            if (e && m_fifo.size() > 0) begin
                nst = M_RUN;
                nph = 3;
            end
        end else begin
            nph = (m_ph + 1) % 4;
            if (nph == 0) begin
                if (m_fifo.size() > 0) begin
                    p = m_fifo.pop_front();
                    m_i = p[3:2]; m_q = p[1:0]; m_stb = 1;
                end else if (m_st == M_RUN) begin
                    m_und = 1;
                end else if (!e) begin
                    nst = M_IDLE;
                    m_half = 0;
                end
            end
            if (m_st == M_RUN && !e) nst = M_DRAIN;
            if (m_st == M_DRAIN && e) nst = M_RUN;
        end
        if (acc) begin
            if (m_half) begin
                m_fifo.push_back({sym_of(m_hbit), sym_of(b)});
                m_half = 0;
            end else begin
                m_half = 1;
                m_hbit = b;
            end
        end
        if (m_st == M_IDLE && nst == M_RUN) m_ucnt = 0;
        else if (m_und && m_ucnt < 255) m_ucnt++;
        m_st = nst;
        m_ph = nph;
        m_busy = (nst != M_IDLE);
    endtask

    task automatic check_outputs();
        check("data_I_out", 32'(data_I_out), 32'(m_i));
        check("data_Q_out", 32'(data_Q_out), 32'(m_q));
        check("sym_strobe", 32'(sym_strobe), 32'(m_stb));
        check("underrun",   32'(underrun),   32'(m_und));
        check("busy",       32'(busy),       32'(m_busy));
`ifdef QPSK_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
    endtask

    // One clock: drive at the falling edge, check ready, step model at the rising edge, check outputs.
    task automatic cycle(input bit e, input bit v, input bit b);
        en = e; bit_valid = v; bit_in = b;
        #1;
        check("bit_ready", 32'(bit_ready), 32'(e && (m_fifo.size() < 2)));
        @(posedge clk_fs);
        model_edge(e, v, b);
        @(negedge clk_fs);
        check_outputs();
    endtask

    // Mid-cycle asynchronous reset with en/valid high; released on a falling edge.
    task automatic do_reset();
        #7;
        en = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check_outputs();
        @(negedge clk_fs);
        @(negedge clk_fs);
        check_outputs();
        rst_n = 1'b1;
    endtask

    int         s_idx [$];
    logic [3:0] s_sym [$];
    int         n_stb;
    int         n_und;
    bit         e_r;
    int         vp;

    initial begin
        rst_n = 1'b0; en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        model_reset();
        #1;
        check("por_bit_ready", 32'(bit_ready), 32'd0);
        check_outputs();
        @(negedge clk_fs);
        rst_n = 1'b1;

        // Bits 0,1 back-to-back: symbol two edges after the second bit, then three zero samples.
        cycle(1, 1, 0);
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        check("s1_early_strobe", 32'(sym_strobe), 32'd0);
        cycle(1, 0, 0);
        check("s1_I", 32'(data_I_out), 32'h1);
        check("s1_Q", 32'(data_Q_out), 32'h3);
        check("s1_strobe", 32'(sym_strobe), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0);
            check("s1_zero_IQ", 32'({data_I_out, data_Q_out}), 32'h0);
            check("s1_zero_strobe", 32'(sym_strobe), 32'd0);
        end
        for (int k = 0; k < 8; k++) cycle(0, 0, 0);

        // Continuous 0,0,1,1,1,0: three symbols four samples apart, no underrun.
        do_reset();
        begin
            bit bits [6];
            bits = '{0, 0, 1, 1, 1, 0};
            s_idx.delete(); s_sym.delete(); n_und = 0;
            for (int k = 1; k <= 13; k++) begin
                if (k <= 6) cycle(1, 1, bits[k-1]);
                else        cycle(1, 0, 0);
                if (sym_strobe) begin
                    s_idx.push_back(k);
                    s_sym.push_back({data_I_out, data_Q_out});
                end
                if (underrun) n_und++;
            end
        end
        check("s2_nsym", 32'(s_idx.size()), 32'd3);
        check("s2_underrun", 32'(n_und), 32'd0);
        if (s_idx.size() == 3) begin
            check("s2_gap0", 32'(s_idx[1] - s_idx[0]), 32'd4);
            check("s2_gap1", 32'(s_idx[2] - s_idx[1]), 32'd4);
            check("s2_sym0", 32'(s_sym[0]), 32'h5);
            check("s2_sym1", 32'(s_sym[1]), 32'hf);
            check("s2_sym2", 32'(s_sym[2]), 32'hd);
        end
        for (int k = 0; k < 8; k++) cycle(0, 0, 0);

        // One pair then starve: second slot underruns for one sample while busy.
        do_reset();
        cycle(1, 1, 1);
        cycle(1, 1, 0);
        for (int k = 3; k <= 9; k++) begin
            cycle(1, 0, 0);
            if (k == 8) begin
                check("s3_underrun", 32'(underrun), 32'd1);
                check("s3_busy", 32'(busy), 32'd1);
                check("s3_IQ", 32'({data_I_out, data_Q_out}), 32'h0);
                check("s3_strobe", 32'(sym_strobe), 32'd0);
            end
            if (k == 9) check("s3_pulse_end", 32'(underrun), 32'd0);
        end
        for (int k = 0; k < 8; k++) cycle(0, 0, 0);

        // Two pairs plus an odd bit, then en dropped: drain both, go idle, drop the half pair.
        do_reset();
        n_stb = 0; n_und = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 5) cycle(1, 1, 32'($urandom) & 1);
            else        cycle(0, 0, 0);
            if (sym_strobe) n_stb++;
            if (underrun) n_und++;
        end
        check("s4_nsym", 32'(n_stb), 32'd2);
        check("s4_underrun", 32'(n_und), 32'd0);
        check("s4_idle", 32'(busy), 32'd0);
        cycle(1, 1, 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0);
        check("s4_half_dropped", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0);

        // Reset at phase 2 with two symbols queued: nothing stale afterwards.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1, 1, 32'($urandom) & 1);
        do_reset();
        n_stb = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0);
            if (sym_strobe || busy) n_stb++;
        end
        check("s5_no_stale", 32'(n_stb), 32'd0);

        // 300 consecutive empty slots.
        do_reset();
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        n_und = 0;
        for (int k = 3; k <= 1206; k++) begin
            cycle(1, 0, 0);
            if (underrun) n_und++;
        end
        check("s6_pulses", 32'(n_und), 32'd300);
`ifdef QPSK_UNDERRUN_CNT_EN
        check("s6_cnt_sat", 32'(underrun_cnt), 32'd255);
`endif
        for (int k = 0; k < 8; k++) cycle(0, 0, 0);

        // Random traffic with en toggling, varying valid density and occasional resets.
        do_reset();
        e_r = 1'b1;
        vp = 60;
        for (int k = 0; k < 2500; k++) begin
            if (k % 250 == 0) vp = int'($urandom_range(20, 100));
            if ($urandom_range(0, 99) < 3) e_r = !e_r;
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle(e_r, $urandom_range(0, 99) < vp, 32'($urandom) & 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
